// File: rtl/k_pulse_monitor.sv
// k_pulse_monitor: watches the K2/K1 control pulses from the Idle/Start/Stop/Clear
// controller. Every K2 must be followed by exactly one K1 within TIMEOUT clocks.
// Completed sequences are counted and protocol violations raise sticky error flags.
// The pulses come from registered outputs on the same clock, so no synchronisers are used.
module k_pulse_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             K2,
  input  logic             K1,
  input  logic             Clr_err,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Cycle_cnt,
  output logic             Err_orphan,
  output logic             Err_double,
  output logic             Err_both,
  output logic             Err_timeout
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // One-hot encoding, so the two all-zero/all-one patterns are illegal and recover to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    ARMED = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [TW-1:0]    timer_r;
  logic [TW-1:0]    timer_s;
  logic             done_s;
  logic [CNT_W-1:0] cnt_s;
  logic             set_orphan_s;
  logic             set_double_s;
  logic             set_both_s;
  logic             set_timeout_s;

  // Busy is a plain decode of the state register.
  assign Busy = (state_r == ARMED);

  // Next-state, timer, Done, count and error-set decisions for the current edge.
  always_comb begin
    state_s       = state_r;
    timer_s       = timer_r;
    done_s        = 1'b0;
    cnt_s         = Cycle_cnt;
    set_orphan_s  = 1'b0;
    set_double_s  = 1'b0;
    set_both_s    = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (K2 && !K1) begin
          state_s = ARMED;
          timer_s = {TW{1'b0}};
        end else if (K1 && !K2) begin
          set_orphan_s = 1'b1;
        end else if (K1 && K2) begin
          set_both_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        // K1 is checked before the timer, so a K1 on the final window edge still wins.
        if (K1 && K2) begin
          state_s    = IDLE;
          set_both_s = 1'b1;
        end else if (K1) begin
          state_s = IDLE;
          done_s  = 1'b1;
          if (Cycle_cnt != CNT_MAX) begin
            cnt_s = Cycle_cnt + CNT_W'(1);
          end else begin
            cnt_s = Cycle_cnt;
          end
        end else if (K2) begin
          set_double_s = 1'b1;
          timer_s      = {TW{1'b0}};
        end else if (timer_r == TIMER_LAST) begin
          state_s       = IDLE;
          set_timeout_s = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = {TW{1'b0}};
      end
    endcase
  end

  // State, timer, outputs and sticky flags; a set on the same edge as Clr_err wins.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      timer_r     <= {TW{1'b0}};
      Done        <= 1'b0;
      Cycle_cnt   <= {CNT_W{1'b0}};
      Err_orphan  <= 1'b0;
      Err_double  <= 1'b0;
      Err_both    <= 1'b0;
      Err_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      Done        <= done_s;
      Cycle_cnt   <= cnt_s;
      Err_orphan  <= set_orphan_s  | (Err_orphan  & ~Clr_err);
      Err_double  <= set_double_s  | (Err_double  & ~Clr_err);
      Err_both    <= set_both_s    | (Err_both    & ~Clr_err);
      Err_timeout <= set_timeout_s | (Err_timeout & ~Clr_err);
    end
  end

endmodule

// File: tb/tb_k_pulse_monitor.sv
// Scoreboard bench for k_pulse_monitor: directed scenarios plus random pulse traffic.
// The reference model tracks an absolute deadline edge rather than a running timer.
module tb_k_pulse_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             K2 = 1'b0;
  logic             K1 = 1'b0;
  logic             Clr_err = 1'b0;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Cycle_cnt;
  logic             Err_orphan;
  logic             Err_double;
  logic             Err_both;
  logic             Err_timeout;

  k_pulse_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .K2(K2), .K1(K1), .Clr_err(Clr_err),
    .Busy(Busy), .Done(Done), .Cycle_cnt(Cycle_cnt),
    .Err_orphan(Err_orphan), .Err_double(Err_double),
    .Err_both(Err_both), .Err_timeout(Err_timeout)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic             eo;
    logic             ed;
    logic             eb;
    logic             et;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  bit      m_armed = 1'b0;
  longint  m_deadline = 0;
  int      m_cnt = 0;
  bit      m_eo = 1'b0, m_ed = 1'b0, m_eb = 1'b0, m_et = 1'b0;
  longint  edge_no = 0;

  // Drive one edge worth of inputs and push the expected post-edge outputs.
  task automatic step(input bit rst, input bit k1, input bit k2, input bit clr);
    obs_t e;
    bit done_v = 1'b0;
    bit so = 1'b0, sd = 1'b0, sb = 1'b0, st = 1'b0;
    @(negedge Clock);
    Reset = rst; K1 = k1; K2 = k2; Clr_err = clr;
    edge_no++;
    if (rst) begin
      m_armed = 1'b0; m_cnt = 0;
      m_eo = 1'b0; m_ed = 1'b0; m_eb = 1'b0; m_et = 1'b0;
    end else begin
      if (!m_armed) begin
        if (k2 && !k1) begin
          m_armed = 1'b1;
          m_deadline = edge_no + TIMEOUT;
        end else if (k1 && !k2) so = 1'b1;
        else if (k1 && k2) sb = 1'b1;
      end else begin
        if (k1 && k2) begin
          m_armed = 1'b0; sb = 1'b1;
        end else if (k1) begin
          m_armed = 1'b0; done_v = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (k2) begin
          sd = 1'b1; m_deadline = edge_no + TIMEOUT;
        end else if (edge_no == m_deadline) begin
          m_armed = 1'b0; st = 1'b1;
        end
      end
      m_eo = so | (m_eo & !clr);
      m_ed = sd | (m_ed & !clr);
      m_eb = sb | (m_eb & !clr);
      m_et = st | (m_et & !clr);
    end
    e.busy = m_armed; e.done = done_v; e.cnt = m_cnt[CNT_W-1:0];
    e.eo = m_eo; e.ed = m_ed; e.eb = m_eb; e.et = m_et;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after each rising edge, pop the expected response and compare.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge Clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {Busy, Done, Cycle_cnt, Err_orphan, Err_double, Err_both, Err_timeout};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t actual busy=%b done=%b cnt=%0d eo=%b ed=%b eb=%b et=%b required busy=%b done=%b cnt=%0d eo=%b ed=%b eb=%b et=%b",
                   $time, a.busy, a.done, a.cnt, a.eo, a.ed, a.eb, a.et,
                   e.busy, e.done, e.cnt, e.eo, e.ed, e.eb, e.et);
        end
      end
    end
  end

  // Stimulus: test-plan scenarios, then randomized traffic.
  initial begin
    // Basic sequence: K2, K1 three edges later.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Timeout, then an orphan K1.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // K1 exactly on the last window edge.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(TIMEOUT - 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Double K2 restarts the window; then K1&K2 in IDLE and in ARMED.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(TIMEOUT - 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Saturation: 256 back-to-back sequences from zero.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle(2);
    // Reset while armed with Err_double set, then orphan K1 with Clr_err.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) < 1, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4);
    end
    idle(4);
    repeat (3) @(posedge Clock);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
